// File: rtl/i2cmb_cmd_sequencer.sv
// Wishbone master that drives the i2cmb register set (CSR/DPR/CMDR) through
// complete I2C transfers: Set Bus, Start, Address, data bytes, Stop.
module i2cmb_cmd_sequencer #(
  parameter int LEN_W   = 8,
  parameter int TIMEOUT = 65535
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       req_bus,
  input  logic [6:0]       req_addr,
  input  logic             req_rnw,
  input  logic [LEN_W-1:0] req_len,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [7:0]       wr_data,
  output logic             rd_valid,
  output logic [7:0]       rd_data,
  output logic             done,
  output logic [2:0]       status,
  output logic [1:0]       wb_adr_o,
  output logic [7:0]       wb_dat_o,
  input  logic [7:0]       wb_dat_i,
  output logic             wb_cyc_o,
  output logic             wb_stb_o,
  output logic             wb_we_o,
  input  logic             wb_ack_i,
  input  logic             irq_i
);
  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  typedef enum logic [3:0] {
    S_INIT, S_INIT_W, S_IDLE, S_STEP, S_DPR_W, S_CMD, S_CMD_W, S_IRQ,
    S_STAT_R, S_DECODE, S_WRWAIT, S_WRTAKE, S_RD_DPR, S_DONE
  } state_t;
  typedef enum logic [2:0] {
    P_SETBUS, P_START, P_ADDR, P_WDATA, P_RDATA, P_STOP
  } phase_t;

  state_t           r_state;
  phase_t           r_phase;
  logic [3:0]       r_bus;
  logic [6:0]       r_addr;
  logic             r_rnw;
  logic [LEN_W-1:0] r_cnt;
  logic [7:0]       r_wbyte;
  logic [2:0]       r_stat;     // {nak, al, err} from last CMDR read
  logic [2:0]       r_status;   // {nak, al, err/timeout}
  logic [TW-1:0]    r_timer;
  logic             r_req_ready, r_wr_ready, r_rd_valid, r_done;
  logic [7:0]       r_rd_data, r_dat;
  logic [1:0]       r_adr;
  logic             r_cyc, r_stb, r_we;
  logic [7:0]       w_cmd, w_op;
  logic             w_has_op, w_last;

  assign req_ready = r_req_ready;
  assign wr_ready  = r_wr_ready;
  assign rd_valid  = r_rd_valid;
  assign rd_data   = r_rd_data;
  assign done      = r_done;
  assign status    = r_status;
  assign wb_adr_o  = r_adr;
  assign wb_dat_o  = r_dat;
  assign wb_cyc_o  = r_cyc;
  assign wb_stb_o  = r_stb;
  assign wb_we_o   = r_we;

  assign w_last = (r_cnt == LEN_W'(1));

  // Command byte and optional DPR operand for the current phase
  always_comb begin
    w_cmd    = 8'h05;
    w_op     = 8'h00;
    w_has_op = 1'b0;
    case (r_phase)
      P_SETBUS: begin w_cmd = 8'h06; w_op = {4'h0, r_bus}; w_has_op = 1'b1; end
      P_START:  w_cmd = 8'h04;
      P_ADDR:   begin w_cmd = 8'h01; w_op = {r_addr, r_rnw}; w_has_op = 1'b1; end
      P_WDATA:  begin w_cmd = 8'h01; w_op = r_wbyte; w_has_op = 1'b1; end
      P_RDATA:  w_cmd = w_last ? 8'h03 : 8'h02;  // NAK the final byte
      default:  w_cmd = 8'h05;
    endcase
  end

  // Sequencer FSM with Wishbone access handling; all outputs registered
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= S_INIT;   r_phase <= P_SETBUS;
      r_bus <= '0;         r_addr <= '0;       r_rnw <= 1'b0;
      r_cnt <= '0;         r_wbyte <= '0;      r_stat <= '0;
      r_status <= '0;      r_timer <= '0;
      r_req_ready <= 1'b0; r_wr_ready <= 1'b0; r_rd_valid <= 1'b0;
      r_done <= 1'b0;      r_rd_data <= '0;    r_dat <= '0;
      r_adr <= '0;         r_cyc <= 1'b0;      r_stb <= 1'b0;
      r_we <= 1'b0;
    end else begin
      r_done     <= 1'b0;
      r_rd_valid <= 1'b0;
      case (r_state)
        S_INIT: begin
          r_cyc <= 1'b1; r_stb <= 1'b1; r_we <= 1'b1;
          r_adr <= 2'd0; r_dat <= 8'hC0;  // core enable + interrupt enable
          r_state <= S_INIT_W;
        end
        S_INIT_W: if (wb_ack_i) begin
          r_cyc <= 1'b0; r_stb <= 1'b0; r_we <= 1'b0;
          r_req_ready <= 1'b1;
          r_state <= S_IDLE;
        end
        S_IDLE: if (req_valid) begin
          r_bus <= req_bus; r_addr <= req_addr; r_rnw <= req_rnw;
          r_cnt <= req_len; r_phase <= P_SETBUS;
          r_req_ready <= 1'b0;
          if (req_len == '0) begin
            r_status <= 3'b001;
            r_state  <= S_DONE;
          end else begin
            r_status <= 3'b000;
            r_state  <= S_STEP;
          end
        end
        S_STEP: begin
          r_cyc <= 1'b1; r_stb <= 1'b1; r_we <= 1'b1;
          if (w_has_op) begin
            r_adr <= 2'd1; r_dat <= w_op; r_state <= S_DPR_W;
          end else begin
            r_adr <= 2'd2; r_dat <= w_cmd; r_state <= S_CMD_W;
          end
        end
        S_DPR_W: if (wb_ack_i) begin
          r_cyc <= 1'b0; r_stb <= 1'b0; r_we <= 1'b0;
          r_state <= S_CMD;
        end
        S_CMD: begin
          r_cyc <= 1'b1; r_stb <= 1'b1; r_we <= 1'b1;
          r_adr <= 2'd2; r_dat <= w_cmd;
          r_state <= S_CMD_W;
        end
        S_CMD_W: if (wb_ack_i) begin
          r_cyc <= 1'b0; r_stb <= 1'b0; r_we <= 1'b0;
          r_timer <= '0;
          r_state <= S_IRQ;
        end
        S_IRQ: begin
          if (irq_i) begin
            r_cyc <= 1'b1; r_stb <= 1'b1; r_we <= 1'b0; r_adr <= 2'd2;
            r_state <= S_STAT_R;
          end else if (r_timer == TW'(TIMEOUT - 1)) begin
            r_status[0] <= 1'b1;
            if (r_phase == P_STOP) r_state <= S_DONE;
            else begin r_phase <= P_STOP; r_state <= S_STEP; end
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        S_STAT_R: if (wb_ack_i) begin
          r_cyc <= 1'b0; r_stb <= 1'b0;
          r_stat <= wb_dat_i[6:4];
          r_state <= S_DECODE;
        end
        S_DECODE: begin
          if (r_stat[1]) begin
            // arbitration lost: bus no longer ours, so no STOP
            r_status[1] <= 1'b1;
            r_state <= S_DONE;
          end else if (r_stat[0]) begin
            r_status[0] <= 1'b1;
            if (r_phase == P_STOP) r_state <= S_DONE;
            else begin r_phase <= P_STOP; r_state <= S_STEP; end
          end else if (r_stat[2] && (r_phase == P_ADDR || r_phase == P_WDATA)) begin
            r_status[2] <= 1'b1;
            r_phase <= P_STOP; r_state <= S_STEP;
          end else begin
            case (r_phase)
              P_SETBUS: begin r_phase <= P_START; r_state <= S_STEP; end
              P_START:  begin r_phase <= P_ADDR;  r_state <= S_STEP; end
              P_ADDR: begin
                if (r_rnw) begin r_phase <= P_RDATA; r_state <= S_STEP; end
                else begin r_phase <= P_WDATA; r_state <= S_WRWAIT; end
              end
              P_WDATA: begin
                if (w_last) begin r_phase <= P_STOP; r_state <= S_STEP; end
                else begin r_cnt <= r_cnt - LEN_W'(1); r_state <= S_WRWAIT; end
              end
              P_RDATA: begin
                r_cyc <= 1'b1; r_stb <= 1'b1; r_we <= 1'b0; r_adr <= 2'd1;
                r_state <= S_RD_DPR;
              end
              default: r_state <= S_DONE;
            endcase
          end
        end
        // one-cycle wr_ready pulse; wr_valid is held by the producer
        S_WRWAIT: if (wr_valid) begin
          r_wr_ready <= 1'b1;
          r_state <= S_WRTAKE;
        end
        S_WRTAKE: begin
          r_wr_ready <= 1'b0;
          r_wbyte <= wr_data;
          r_state <= S_STEP;
        end
        S_RD_DPR: if (wb_ack_i) begin
          r_cyc <= 1'b0; r_stb <= 1'b0;
          r_rd_data <= wb_dat_i;
          r_rd_valid <= 1'b1;
          if (w_last) r_phase <= P_STOP;
          else r_cnt <= r_cnt - LEN_W'(1);
          r_state <= S_STEP;
        end
        S_DONE: begin
          r_done <= 1'b1;
          r_req_ready <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_INIT;
      endcase
    end
  end
endmodule

// File: tb/tb_i2cmb_cmd_sequencer.sv
// Directed bench for i2cmb_cmd_sequencer with a small i2cmb register model.
module tb_i2cmb_cmd_sequencer;
  logic       clk = 0, rst_n = 0;
  logic       req_valid = 0, req_ready, req_rnw = 0;
  logic [3:0] req_bus = 0;
  logic [6:0] req_addr = 0;
  logic [7:0] req_len = 0;
  logic       wr_valid, wr_ready, rd_valid, done;
  logic [7:0] wr_data, rd_data;
  logic [2:0] status;
  logic [1:0] wb_adr;
  logic [7:0] wb_dat_o, wb_dat_i = 0;
  logic       wb_cyc, wb_stb, wb_we, wb_ack = 0, irq = 0;

  int checks = 0, errors = 0;

  // bench-owned stimulus settings (written only by the initial block)
  logic       clr_log = 0, withhold_start = 0, nak_addr = 0;
  logic [7:0] rd_mem [4];
  logic [7:0] wr_mem [4];
  int         wr_n = 0;

  // slave model / log state (written only by the always blocks)
  logic [7:0] csr_q[$], dpr_q[$], cmdr_q[$], rd_q[$];
  int         t_cmd[$];
  int         cyc_n = 0, rd_idx = 0, wr_idx = 0, irq_cnt = 0;
  int         done_cnt = 0, overlap = 0;
  logic [7:0] stat_val = 8'h80;
  logic [2:0] last_status = 0;
  logic       wr_ready_seen = 0;

  i2cmb_cmd_sequencer #(.LEN_W(8), .TIMEOUT(16)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_bus(req_bus),
    .req_addr(req_addr), .req_rnw(req_rnw), .req_len(req_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_data(rd_data), .done(done), .status(status),
    .wb_adr_o(wb_adr), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
    .wb_cyc_o(wb_cyc), .wb_stb_o(wb_stb), .wb_we_o(wb_we),
    .wb_ack_i(wb_ack), .irq_i(irq)
  );

  always #5 clk = ~clk;

  assign wr_valid = (wr_idx < wr_n);
  assign wr_data  = wr_mem[wr_idx[1:0]];

  // i2cmb register model: 1-cycle ack, irq 3 cycles after each CMDR write
  always @(posedge clk) begin
    cyc_n <= cyc_n + 1;
    if (clr_log) begin
      csr_q.delete(); dpr_q.delete(); cmdr_q.delete(); t_cmd.delete();
      rd_idx <= 0; wr_idx <= 0;
    end else if (wr_valid && wr_ready) wr_idx <= wr_idx + 1;
    if (!rst_n) begin
      wb_ack <= 0; irq <= 0; irq_cnt <= 0;
    end else begin
      wb_ack <= 0;
      if (wb_cyc && wb_stb && !wb_ack) begin
        wb_ack <= 1;
        if (!wb_we) begin
          wb_dat_i <= (wb_adr == 2) ? stat_val : (wb_adr == 1) ? rd_mem[rd_idx[1:0]] : 8'h00;
          if (wb_adr == 1) rd_idx <= rd_idx + 1;
        end
      end
      if (irq_cnt != 0) begin
        irq_cnt <= irq_cnt - 1;
        if (irq_cnt == 1) irq <= 1;
      end
      if (wb_cyc && wb_stb && wb_ack) begin
        if (wb_we) begin
          if (wb_adr == 0) csr_q.push_back(wb_dat_o);
          if (wb_adr == 1) dpr_q.push_back(wb_dat_o);
          if (wb_adr == 2) begin
            cmdr_q.push_back(wb_dat_o);
            t_cmd.push_back(cyc_n);
            if (!(withhold_start && wb_dat_o == 8'h04)) irq_cnt <= 3;
            stat_val <= (nak_addr && wb_dat_o == 8'h01) ? 8'h40 : 8'h80;
          end
        end else if (wb_adr == 2) irq <= 0;
      end
    end
  end

  // output monitor
  always @(negedge clk) begin
    if (clr_log) begin
      rd_q.delete(); done_cnt <= 0; wr_ready_seen <= 0;
    end else begin
      if (rd_valid) rd_q.push_back(rd_data);
      if (done) begin done_cnt <= done_cnt + 1; last_status <= status; end
      if (wr_ready) wr_ready_seen <= 1;
    end
    if (done && rd_valid) overlap <= overlap + 1;
  end

  task automatic clear_log();
    @(negedge clk) clr_log = 1;
    @(posedge clk); @(posedge clk); #1 clr_log = 0;
  endtask

  task automatic do_req(input logic [3:0] b, input logic [6:0] a, input logic rnw, input logic [7:0] len);
    int n = 0;
    @(negedge clk);
    req_bus = b; req_addr = a; req_rnw = rnw; req_len = len; req_valid = 1;
    while (!req_ready && n < 200) begin @(negedge clk); n++; end
    checks++;
    if (!req_ready) begin errors++; $display("FAIL req_accept: req_ready=%0b required 1", req_ready); end
    @(posedge clk); #1 req_valid = 0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (done_cnt == 0 && n < 2000) begin @(posedge clk); n++; end
    checks++;
    if (done_cnt != 1) begin errors++; $display("FAIL done_seen: count=%0d required 1", done_cnt); end
  endtask

  task automatic wait_ready(input string nm);
    int n = 0;
    while (!req_ready && n < 200) begin @(negedge clk); n++; end
    checks++;
    if (!req_ready) begin errors++; $display("FAIL %s: req_ready=0 required 1", nm); end
  endtask

  task automatic test_reset();
    rst_n = 0;
    repeat (3) @(posedge clk);
    #1 checks++;
    if ({wb_cyc, wb_stb, wb_we, req_ready, done, rd_valid, wr_ready, status} !== 10'b0) begin
      errors++; $display("FAIL reset_outputs: got %b required 0", {wb_cyc, wb_stb, wb_we, req_ready, done, rd_valid, wr_ready, status});
    end
    @(negedge clk) rst_n = 1;
    @(posedge clk); #1 checks++;
    if (req_ready !== 1'b0) begin errors++; $display("FAIL ready_before_init: got %b required 0", req_ready); end
    wait_ready("init_complete");
    checks++;
    if (csr_q.size() != 1 || csr_q[0] !== 8'hC0) begin
      errors++; $display("FAIL init_csr: n=%0d first=%h required n=1 C0", csr_q.size(), (csr_q.size() > 0) ? csr_q[0] : 8'hxx);
    end
  endtask

  task automatic test_write();
    logic [7:0] ec [6] = '{8'h06, 8'h04, 8'h01, 8'h01, 8'h01, 8'h05};
    logic [7:0] ed [4] = '{8'h02, 8'h44, 8'h5A, 8'hA5};
    wr_n = 0; clear_log();
    wr_mem[0] = 8'h5A; wr_mem[1] = 8'hA5; wr_n = 2;
    do_req(4'd2, 7'h22, 1'b0, 8'd2);
    checks++;
    if (req_ready !== 1'b0) begin errors++; $display("FAIL busy_ready: got %b required 0", req_ready); end
    wait_done();
    checks++;
    if (cmdr_q.size() != 6) begin errors++; $display("FAIL wr_cmdr_count: got %0d required 6", cmdr_q.size()); end
    else for (int i = 0; i < 6; i++) begin
      checks++;
      if (cmdr_q[i] !== ec[i]) begin errors++; $display("FAIL wr_cmdr[%0d]: got %h required %h", i, cmdr_q[i], ec[i]); end
    end
    checks++;
    if (dpr_q.size() != 4) begin errors++; $display("FAIL wr_dpr_count: got %0d required 4", dpr_q.size()); end
    else for (int i = 0; i < 4; i++) begin
      checks++;
      if (dpr_q[i] !== ed[i]) begin errors++; $display("FAIL wr_dpr[%0d]: got %h required %h", i, dpr_q[i], ed[i]); end
    end
    checks++;
    if (last_status !== 3'b000) begin errors++; $display("FAIL wr_status: got %b required 000", last_status); end
  endtask

  task automatic test_read();
    logic [7:0] ec [7] = '{8'h06, 8'h04, 8'h01, 8'h02, 8'h02, 8'h03, 8'h05};
    logic [7:0] er [3] = '{8'h11, 8'h22, 8'h33};
    wr_n = 0; clear_log();
    rd_mem[0] = 8'h11; rd_mem[1] = 8'h22; rd_mem[2] = 8'h33;
    do_req(4'd0, 7'h22, 1'b1, 8'd3);
    wait_done();
    checks++;
    if (cmdr_q.size() != 7) begin errors++; $display("FAIL rd_cmdr_count: got %0d required 7", cmdr_q.size()); end
    else for (int i = 0; i < 7; i++) begin
      checks++;
      if (cmdr_q[i] !== ec[i]) begin errors++; $display("FAIL rd_cmdr[%0d]: got %h required %h", i, cmdr_q[i], ec[i]); end
    end
    checks++;
    if (dpr_q.size() != 2 || dpr_q[1] !== 8'h45 || dpr_q[0] !== 8'h00) begin
      errors++; $display("FAIL rd_dpr: n=%0d required bus 00 then addr byte 45", dpr_q.size());
    end
    checks++;
    if (rd_q.size() != 3) begin errors++; $display("FAIL rd_count: got %0d required 3", rd_q.size()); end
    else for (int i = 0; i < 3; i++) begin
      checks++;
      if (rd_q[i] !== er[i]) begin errors++; $display("FAIL rd_data[%0d]: got %h required %h", i, rd_q[i], er[i]); end
    end
    checks++;
    if (last_status !== 3'b000) begin errors++; $display("FAIL rd_status: got %b required 000", last_status); end
  endtask

  task automatic test_nak();
    logic [7:0] ec [4] = '{8'h06, 8'h04, 8'h01, 8'h05};
    wr_n = 0; clear_log();
    wr_mem[0] = 8'h77; wr_mem[1] = 8'h88; wr_n = 2; nak_addr = 1;
    do_req(4'd1, 7'h10, 1'b0, 8'd2);
    wait_done();
    nak_addr = 0;
    checks++;
    if (cmdr_q.size() != 4) begin errors++; $display("FAIL nak_cmdr_count: got %0d required 4", cmdr_q.size()); end
    else for (int i = 0; i < 4; i++) begin
      checks++;
      if (cmdr_q[i] !== ec[i]) begin errors++; $display("FAIL nak_cmdr[%0d]: got %h required %h", i, cmdr_q[i], ec[i]); end
    end
    checks++;
    if (dpr_q.size() != 2) begin errors++; $display("FAIL nak_dpr_count: got %0d required 2", dpr_q.size()); end
    checks++;
    if (last_status !== 3'b100) begin errors++; $display("FAIL nak_status: got %b required 100", last_status); end
    checks++;
    if (wr_ready_seen !== 1'b0 || wr_idx != 0) begin
      errors++; $display("FAIL nak_wr_ready: seen=%b consumed=%0d required 0 0", wr_ready_seen, wr_idx);
    end
  endtask

  task automatic test_timeout();
    logic [7:0] ec [3] = '{8'h06, 8'h04, 8'h05};
    wr_n = 0; clear_log();
    withhold_start = 1;
    do_req(4'd3, 7'h2A, 1'b0, 8'd1);
    wait_done();
    withhold_start = 0;
    checks++;
    if (cmdr_q.size() != 3) begin errors++; $display("FAIL to_cmdr_count: got %0d required 3", cmdr_q.size()); end
    else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (cmdr_q[i] !== ec[i]) begin errors++; $display("FAIL to_cmdr[%0d]: got %h required %h", i, cmdr_q[i], ec[i]); end
      end
      // 16 wait cycles + 1 step + 2-cycle STOP write
      checks++;
      if (t_cmd[2] - t_cmd[1] != 19) begin
        errors++; $display("FAIL to_gap: got %0d cycles required 19", t_cmd[2] - t_cmd[1]);
      end
    end
    checks++;
    if (last_status !== 3'b001) begin errors++; $display("FAIL to_status: got %b required 001", last_status); end
  endtask

  task automatic test_zero_len();
    wr_n = 0; clear_log();
    do_req(4'd1, 7'h11, 1'b0, 8'd0);
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL zl_done_early: got %b required 0", done); end
    @(posedge clk); #1 checks++;
    if (done !== 1'b1 || status !== 3'b001) begin
      errors++; $display("FAIL zl_done: done=%b status=%b required 1 001", done, status);
    end
    repeat (3) @(posedge clk);
    #1 checks++;
    if (csr_q.size() + dpr_q.size() + cmdr_q.size() != 0 || wb_cyc !== 1'b0) begin
      errors++; $display("FAIL zl_no_wb: writes=%0d cyc=%b required 0 0", csr_q.size() + dpr_q.size() + cmdr_q.size(), wb_cyc);
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    wr_n = 0; clear_log();
    wr_mem[0] = 8'h3C; wr_mem[1] = 8'hC3; wr_n = 2;
    do_req(4'd1, 7'h33, 1'b0, 8'd2);
    while ((wr_idx == 0 || !wb_cyc) && n < 500) begin @(negedge clk); n++; end
    checks++;
    if (!wb_cyc) begin errors++; $display("FAIL mid_reach_data: cyc=%b required 1", wb_cyc); end
    rst_n = 0;
    #1 checks++;
    if (wb_cyc !== 1'b0 || req_ready !== 1'b0) begin
      errors++; $display("FAIL mid_abandon: cyc=%b ready=%b required 0 0", wb_cyc, req_ready);
    end
    wr_n = 0; clear_log();
    @(negedge clk) rst_n = 1;
    wait_ready("mid_reinit");
    checks++;
    if (csr_q.size() != 1 || csr_q[0] !== 8'hC0) begin
      errors++; $display("FAIL mid_init_csr: n=%0d required one C0 write", csr_q.size());
    end
  endtask

  task automatic test_no_overlap();
    checks++;
    if (overlap != 0) begin errors++; $display("FAIL rd_done_overlap: got %0d required 0", overlap); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_nak();
    test_timeout();
    test_zero_len();
    test_no_overlap();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
